delay_list_manager: RTL and testbench
=====================================

# delay_list_manager

Hardware delayed-task list for the RTOS IP, directly upstream of `lists_manager`. It stores up to DEPTH sleeping tasks as (task id, absolute wake tick) pairs. On each scheduler tick it scans the stored tasks for expired deadlines. Each expired task is returned to the ready list through a valid/ready wake handshake that drives the list manager's re-insert path.

## Interface
Parameters:
- `DEPTH`, 16: number of delay slots; range 2..64.
- `ID_W`, 8: task id width.
- `TICK_W`, 32: tick counter and delay width.

Ports:
- `aclk` input 1: sole clock, rising edge.
- `aresetn` input 1: reset; asynchronous, active-low.
- `tick_in` input 1: tick strobe; rising edge detected internally.
- `tickval_in` input TICK_W: current system tick value.
- `ins_dlylist_in` input 1: single-cycle pulse; put `id_task_in` to sleep for `valuedelay_in` ticks.
- `rem_dlylist_in` input 1: single-cycle pulse; cancel the sleep of `id_task_in`.
- `id_task_in` input ID_W: task id for an insert or remove request.
- `valuedelay_in` input TICK_W: relative delay in ticks; must be < 2^(TICK_W-1).
- `wake_valid_out` output 1: an expired task is presented.
- `wake_id_out` output ID_W: id of the expired task.
- `wake_ready_in` input 1: consumer (`lists_manager` insert) accepts the wake.
- `count_out` output $clog2(DEPTH+1): number of occupied slots.
- `empty_out` output 1: count == 0.
- `full_out` output 1: count == DEPTH.
- `busy_out` output 1: FSM not in IDLE.
- `err_out` output 1: one-cycle pulse on a dropped or illegal request.

## Operation
- Slot storage: valid bit, id, and wake = `tickval_in` + `valuedelay_in`, computed modulo 2^TICK_W when the request is captured.
- Expiry test is wrap-safe: a slot is expired iff the signed value (`tickval_in` − wake) ≥ 0.
- Request capture: a one-deep pending-op register captures insert/remove in any cycle, with the wake value computed at capture. The pending op is applied in IDLE, taking one cycle.
- Request is dropped with `err_out` if the pending register is already occupied or the op is illegal:
  - both strobes asserted in the same cycle;
  - insert while full with no id match;
  - remove with no id match.
- Insert of an id already present overwrites that slot's wake in place; count is unchanged.
- Otherwise an insert uses the lowest free slot.
- Remove clears the matching slot.
- Tick events: a `tick_in` rising edge sets `tick_pend`. Further edges while `tick_pend` is set merge into it; no tick is lost, because expiry is absolute.
- FSM:
  - IDLE: the pending op has priority, and one op is applied per cycle. Otherwise, if `tick_pend` is set, clear it, set idx=0, go to SCAN.
  - SCAN: examine slot idx.
    - Valid and expired: latch id, go to EMIT.
    - Otherwise: idx++. After idx==DEPTH−1, return to IDLE.
  - EMIT: `wake_valid_out`=1 with `wake_id_out` held stable until `wake_ready_in`. On handshake, clear the slot, decrement count, idx++, then go to SCAN, or to IDLE if it was the last slot.
- Remove requests for an id latched in EMIT complete after the handshake: the slot is already freed, so the remove finds no match and `err_out` pulses.

## Timing
- Reset: all slots invalid, count 0, `empty_out`=1, and every other output 0. FSM enters IDLE, `tick_pend` and the pending register are cleared.
- Reset asserted mid-scan or mid-EMIT drops `wake_valid_out` immediately (asynchronously) and discards all state.
- Insert pulse at cycle t, FSM idle: slot written at edge t+2, and `count_out` updates at t+2.
- Tick edge at cycle t, FSM idle with no pending op: SCAN of slot 0 at t+2. If slot i is the first expired slot, `wake_valid_out` rises at t+3+i.
- A full scan with no expiries takes DEPTH cycles. Each expiry adds 1 cycle plus the consumer stall.
- `wake_valid_out` never deasserts without a handshake, except at reset.
- Wakes are emitted in slot-index order within one scan.

## Structure
- Shared package `rtos_pkg`:
  - `ID_W`/`TICK_W` defaults;
  - typedef `dly_entry_t` {valid, id, wake};
  - enum `dly_op_e` {NONE, INS, REM};
  - FSM state enum {IDLE, SCAN, EMIT}.
- Sub-module `dlylist_find`: combinational, over the slot array. Produces `free_idx`/`free_hit` (lowest invalid slot) and `match_idx`/`match_hit` (valid slot with id == request id).

## Test plan
- Insert id 1 delay 0x10 at tickval 0x05 → slot 0, wake 0x15, count 1. Ticks up to 0x14 produce no wake. Tick 0x15 produces `wake_valid_out` with id 1; after ready, count 0 and `empty_out`=1.
- Wrap: tickval 0xFFFFFFF0, insert id 3 delay 0x20 → wake 0x00000010. No wake at tick 0xFFFFFFFF or 0x0F; wake at tick 0x10.
- Fill 16 slots (ids 0–15, delay 5), then insert id 20 → `err_out` pulse and count stays 16. Re-insert id 4 with delay 9 → accepted in place, no error.
- Remove id 7 before expiry → count 15 and no wake for 7. Remove id 7 again → `err_out`.
- Ids 2, 5, 9 expire on the same tick, with `wake_ready_in` held low 4 cycles per wake → wakes in order 2, 5, 9. `wake_id_out` stays stable while stalled. A second tick during the scan triggers exactly one rescan.
- Assert `aresetn` low during EMIT → `wake_valid_out` drops at once; after release, count 0 and no wakes.

Source files
------------

// File: rtl/rtos_pkg.sv
// Shared types for the RTOS IP blocks.
//   DefIdW / DefTickW : default task id and tick widths
//   dly_entry_t       : packed view of one delay slot {valid, id, wake}
//   dly_op_e          : pending request kind held by the delay list
//   dly_state_e       : delay list scan FSM states
package rtos_pkg;

  localparam int unsigned DefIdW   = 8;
  localparam int unsigned DefTickW = 32;

  typedef struct packed {
    logic                valid;
    logic [DefIdW-1:0]   id;
    logic [DefTickW-1:0] wake;
  } dly_entry_t;

  typedef enum logic [1:0] {
    OpNone = 2'd0,
    OpIns  = 2'd1,
    OpRem  = 2'd2
  } dly_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StEmit = 2'd2
  } dly_state_e;

endpackage

// File: rtl/dlylist_find.sv
// Combinational slot search over the delay list.
//   valid_i     : per-slot occupied flags
//   ids_i       : per-slot task ids
//   req_id_i    : id being looked up
//   free_idx_o  : lowest unoccupied slot, free_hit_o set when one exists
//   match_idx_o : occupied slot holding req_id_i, match_hit_o set when found
module dlylist_find #(
  parameter int unsigned  DEPTH = 16,
  parameter int unsigned  ID_W  = 8,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [ID_W-1:0]  ids_i [DEPTH],
  input  logic [ID_W-1:0]  req_id_i,
  output logic [IdxW-1:0]  free_idx_o,
  output logic             free_hit_o,
  output logic [IdxW-1:0]  match_idx_o,
  output logic             match_hit_o
);

  always_comb begin
    free_idx_o  = '0;
    free_hit_o  = 1'b0;
    match_idx_o = '0;
    match_hit_o = 1'b0;
    // Walk downwards so the lowest qualifying index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_hit_o = 1'b1;
        free_idx_o = IdxW'(i);
      end
      if (valid_i[i] && (ids_i[i] == req_id_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/delay_list_manager.sv
// Hardware delayed-task list. Holds up to DEPTH sleeping tasks as (id, absolute
// wake tick); each tick strobe rising edge triggers a scan that hands expired
// tasks back to the ready list over a valid/ready wake port.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   tick_in            : scheduler tick strobe (rising edge detected here)
//   tickval_in         : current system tick
//   ins_dlylist_in     : pulse, sleep id_task_in for valuedelay_in ticks
//   rem_dlylist_in     : pulse, cancel the sleep of id_task_in
//   wake_*             : expired task handshake towards lists_manager
//   count/empty/full   : occupancy
//   busy_out           : scan in progress
//   err_out            : one-cycle pulse on a dropped or illegal request
module delay_list_manager
  import rtos_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ID_W   = DefIdW,
  parameter int unsigned TICK_W = DefTickW
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       tick_in,
  input  logic [TICK_W-1:0]          tickval_in,
  input  logic                       ins_dlylist_in,
  input  logic                       rem_dlylist_in,
  input  logic [ID_W-1:0]            id_task_in,
  input  logic [TICK_W-1:0]          valuedelay_in,
  output logic                       wake_valid_out,
  output logic [ID_W-1:0]            wake_id_out,
  input  logic                       wake_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       busy_out,
  output logic                       err_out
);

  localparam int unsigned     IdxW    = $clog2(DEPTH);
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  // Slot storage
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ID_W-1:0]   id_q   [DEPTH];
  logic [ID_W-1:0]   id_d   [DEPTH];
  logic [TICK_W-1:0] wake_q [DEPTH];
  logic [TICK_W-1:0] wake_d [DEPTH];
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Scan FSM
  dly_state_e        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   wid_q, wid_d;

  // Tick tracking
  logic              tick_prev_q;
  logic              tick_pend_q, tick_pend_d;

  // One-deep pending request
  dly_op_e           pend_op_q, pend_op_d;
  logic [ID_W-1:0]   pend_id_q, pend_id_d;
  logic [TICK_W-1:0] pend_wake_q, pend_wake_d;

  logic              err_q, err_d;

  logic              tick_rise;
  logic              req_any, req_both;
  logic [IdxW-1:0]   free_idx, match_idx;
  logic              free_hit, match_hit;
  logic [TICK_W-1:0] scan_diff;
  logic              scan_expired;

  dlylist_find #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_find (
    .valid_i     (valid_q),
    .ids_i       (id_q),
    .req_id_i    (pend_id_q),
    .free_idx_o  (free_idx),
    .free_hit_o  (free_hit),
    .match_idx_o (match_idx),
    .match_hit_o (match_hit)
  );

  assign tick_rise = tick_in & ~tick_prev_q;
  assign req_any   = ins_dlylist_in | rem_dlylist_in;
  assign req_both  = ins_dlylist_in & rem_dlylist_in;

  // Deadline reached when (now - wake) is non-negative as a signed value; this
  // stays correct across counter wrap while delays are below half the range.
  assign scan_diff    = tickval_in - wake_q[idx_q];
  assign scan_expired = ~scan_diff[TICK_W-1];

  always_comb begin
    valid_d     = valid_q;
    id_d        = id_q;
    wake_d      = wake_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    idx_d       = idx_q;
    wid_d       = wid_q;
    tick_pend_d = tick_pend_q | tick_rise;
    pend_op_d   = pend_op_q;
    pend_id_d   = pend_id_q;
    pend_wake_d = pend_wake_q;
    err_d       = 1'b0;

    // Capture. A request arriving while the register is still occupied is
    // dropped, including the cycle in which the held op is being applied.
    if (req_any) begin
      if (req_both || (pend_op_q != OpNone)) begin
        err_d = 1'b1;
      end else begin
        pend_op_d   = ins_dlylist_in ? OpIns : OpRem;
        pend_id_d   = id_task_in;
        pend_wake_d = tickval_in + valuedelay_in;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_op_q != OpNone) begin
          pend_op_d = OpNone;
          if (pend_op_q == OpIns) begin
            if (match_hit) begin
              wake_d[match_idx] = pend_wake_q;
            end else if (free_hit) begin
              valid_d[free_idx] = 1'b1;
              id_d[free_idx]    = pend_id_q;
              wake_d[free_idx]  = pend_wake_q;
              cnt_d             = cnt_q + CntW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (match_hit) begin
              valid_d[match_idx] = 1'b0;
              cnt_d              = cnt_q - CntW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (tick_pend_q) begin
          // A new edge in this very cycle stays pending and forces a rescan.
          tick_pend_d = tick_rise;
          idx_d       = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (valid_q[idx_q] && scan_expired) begin
          wid_d   = id_q[idx_q];
          state_d = StEmit;
        end else if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StEmit: begin
        if (wake_ready_in) begin
          valid_d[idx_q] = 1'b0;
          cnt_d          = cnt_q - CntW'(1);
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        wake_q[i] <= '0;
      end
      cnt_q       <= '0;
      state_q     <= StIdle;
      idx_q       <= '0;
      wid_q       <= '0;
      tick_prev_q <= 1'b0;
      tick_pend_q <= 1'b0;
      pend_op_q   <= OpNone;
      pend_id_q   <= '0;
      pend_wake_q <= '0;
      err_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      id_q        <= id_d;
      wake_q      <= wake_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      wid_q       <= wid_d;
      tick_prev_q <= tick_in;
      tick_pend_q <= tick_pend_d;
      pend_op_q   <= pend_op_d;
      pend_id_q   <= pend_id_d;
      pend_wake_q <= pend_wake_d;
      err_q       <= err_d;
    end
  end

  assign wake_valid_out = (state_q == StEmit);
  assign wake_id_out    = wid_q;
  assign count_out      = cnt_q;
  assign empty_out      = (cnt_q == '0);
  assign full_out       = (cnt_q == CntW'(DEPTH));
  assign busy_out       = (state_q != StIdle);
  assign err_out        = err_q;

endmodule

// File: tb/tb_delay_list_manager.sv
module tb_delay_list_manager;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned TICK_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              tick_in = 1'b0;
  logic [TICK_W-1:0] tickval_in = '0;
  logic              ins_dlylist_in = 1'b0;
  logic              rem_dlylist_in = 1'b0;
  logic [ID_W-1:0]   id_task_in = '0;
  logic [TICK_W-1:0] valuedelay_in = '0;
  logic              wake_valid_out;
  logic [ID_W-1:0]   wake_id_out;
  logic              wake_ready_in = 1'b0;
  logic [CNT_W-1:0]  count_out;
  logic              empty_out, full_out, busy_out, err_out;

  delay_list_manager #(.DEPTH(DEPTH), .ID_W(ID_W), .TICK_W(TICK_W)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .tick_in        (tick_in),
    .tickval_in     (tickval_in),
    .ins_dlylist_in (ins_dlylist_in),
    .rem_dlylist_in (rem_dlylist_in),
    .id_task_in     (id_task_in),
    .valuedelay_in  (valuedelay_in),
    .wake_valid_out (wake_valid_out),
    .wake_id_out    (wake_id_out),
    .wake_ready_in  (wake_ready_in),
    .count_out      (count_out),
    .empty_out      (empty_out),
    .full_out       (full_out),
    .busy_out       (busy_out),
    .err_out        (err_out)
  );

  always #5 aclk = ~aclk;

  // Reference model: the set of sleeping tasks by slot, plus expected wake order.
  bit                m_valid [DEPTH];
  logic [ID_W-1:0]   m_id    [DEPTH];
  logic [TICK_W-1:0] m_wake  [DEPTH];
  int                m_cnt = 0;
  logic [ID_W-1:0]   exp_q[$];
  logic [ID_W-1:0]   wake_log[$];

  int vectors = 0, miscompares = 0;
  int err_seen = 0, busy_rises = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0, stall_n = 0, stall_cnt = 0;
  bit pv = 1'b0, pr = 1'b0, pbusy = 1'b0;
  logic [ID_W-1:0] pid = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic int m_find(input logic [ID_W-1:0] id);
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_id[i] == id) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit m_due(input int i, input logic [TICK_W-1:0] now);
    logic [TICK_W-1:0] d;
    d = now - m_wake[i];
    return $signed(d) >= 0;
  endfunction

  // Applies a request to the model; returns 1 when the request must be rejected.
  function automatic int m_apply(input bit i_ins, input bit i_rem, input logic [ID_W-1:0] id,
                                 input logic [TICK_W-1:0] wake);
    int k;
    if (i_ins && i_rem) return 1;
    k = m_find(id);
    if (i_ins) begin
      if (k >= 0) begin
        m_wake[k] = wake;
        return 0;
      end
      k = m_free();
      if (k < 0) return 1;
      m_valid[k] = 1'b1;
      m_id[k]    = id;
      m_wake[k]  = wake;
      m_cnt++;
      return 0;
    end
    if (k < 0) return 1;
    m_valid[k] = 1'b0;
    m_cnt--;
    return 0;
  endfunction

  // Consumer ready: 0 = always ready, 1 = random, 2 = stall stall_n cycles per wake.
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: wake_ready_in = 1'b1;
      1: wake_ready_in = 1'($urandom_range(0, 1));
      default: begin
        if (wake_valid_out && stall_cnt >= stall_n) begin
          wake_ready_in = 1'b1;
          stall_cnt     = 0;
        end else begin
          wake_ready_in = 1'b0;
          if (wake_valid_out) stall_cnt++;
        end
      end
    endcase
  end

  // Wake handshake: must match the next expected expiry in slot order.
  always @(posedge aclk) begin : hs_mon
    int k;
    if (aresetn && wake_valid_out && wake_ready_in) begin
      wake_log.push_back(wake_id_out);
      check("wake expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("wake id", wake_id_out, exp_q.pop_front());
      k = m_find(wake_id_out);
      if (k >= 0) begin
        m_valid[k] = 1'b0;
        m_cnt--;
      end
    end
  end

  // Per-cycle compare of occupancy and wake-port stability.
  always @(negedge aclk) begin
    if (chk_en && aresetn) begin
      check("count", count_out, m_cnt);
      check("empty", empty_out, m_cnt == 0);
      check("full", full_out, m_cnt == DEPTH);
      if (pv && !pr) begin
        check("stall valid held", wake_valid_out, 1);
        check("stall id held", wake_id_out, pid);
      end
      pv  = wake_valid_out;
      pr  = wake_ready_in;
      pid = wake_id_out;
    end else begin
      pv = 1'b0;
    end
  end

  always @(negedge aclk) begin
    if (aresetn && err_out) err_seen++;
    if (busy_out && !pbusy) busy_rises++;
    pbusy = busy_out;
  end

  task automatic do_reset();
    chk_en = 1'b0;
    aresetn = 1'b0;
    ins_dlylist_in = 1'b0;
    rem_dlylist_in = 1'b0;
    tick_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    wake_log.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("reset count", count_out, 0);
    check("reset empty", empty_out, 1);
    check("reset full", full_out, 0);
    check("reset busy", busy_out, 0);
    check("reset wake_valid", wake_valid_out, 0);
    check("reset err", err_out, 0);
    chk_en = 1'b1;
  endtask

  task automatic do_op(input bit i_ins, input bit i_rem, input logic [ID_W-1:0] id,
                       input logic [TICK_W-1:0] dly);
    int e0, exp_err;
    @(posedge aclk);
    #1;
    e0 = err_seen;
    ins_dlylist_in = i_ins;
    rem_dlylist_in = i_rem;
    id_task_in     = id;
    valuedelay_in  = dly;
    @(posedge aclk);
    #1;
    ins_dlylist_in = 1'b0;
    rem_dlylist_in = 1'b0;
    @(posedge aclk);
    // The held op lands in the slot array on this edge.
    exp_err = m_apply(i_ins, i_rem, id, tickval_in + dly);
    repeat (2) @(posedge aclk);
    #1;
    check("op err", err_seen - e0, exp_err);
  endtask

  // Raises one tick; optionally re-ticks at the first wake. lat = cycles to first wake.
  task automatic do_tick(input logic [TICK_W-1:0] tv, input bit retick, output int lat);
    int n, idle_run, low_at;
    bit done, rt_done;
    @(posedge aclk);
    #1;
    tickval_in = tv;
    tick_in    = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_due(i, tv)) exp_q.push_back(m_id[i]);
    lat = -1;
    n = 0;
    idle_run = 0;
    low_at = 1;
    done = 1'b0;
    rt_done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge aclk);
      if (lat < 0 && wake_valid_out) lat = n;
      if (n >= 3 && !busy_out) idle_run++;
      else idle_run = 0;
      if (idle_run >= 3) done = 1'b1;
      @(posedge aclk);
      #1;
      n++;
      if (n == low_at) tick_in = 1'b0;
      if (retick && !rt_done && lat >= 0) begin
        tick_in = 1'b1;
        low_at  = n + 1;
        rt_done = 1'b1;
      end
    end
    tick_in = 1'b0;
    check("scan finished", done, 1);
    check("scan leftover wakes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, e0, b0, sevens, n, r;
    logic [TICK_W-1:0] tv;

    // Basic insert / expiry.
    do_reset();
    tickval_in = 32'h05;
    do_op(1'b1, 1'b0, 8'd1, 32'h10);
    check("t1 model wake", m_wake[0], 32'h15);
    check("t1 count", count_out, 1);
    do_tick(32'h06, 1'b0, lat);
    do_tick(32'h10, 1'b0, lat);
    do_tick(32'h14, 1'b0, lat);
    check("t1 no early wake", wake_log.size(), 0);
    do_tick(32'h15, 1'b0, lat);
    check("t1 wake latency", lat, 3);
    check("t1 wake count", wake_log.size(), 1);
    if (wake_log.size() > 0) check("t1 wake id", wake_log[0], 1);
    check("t1 empty after", empty_out, 1);

    // Wrap-around deadline.
    do_reset();
    tickval_in = 32'hFFFF_FFF0;
    do_op(1'b1, 1'b0, 8'd3, 32'h20);
    check("t2 model wake", m_wake[0], 32'h10);
    do_tick(32'hFFFF_FFFF, 1'b0, lat);
    do_tick(32'h0000_000F, 1'b0, lat);
    check("t2 no early wake", wake_log.size(), 0);
    do_tick(32'h0000_0010, 1'b0, lat);
    check("t2 wake count", wake_log.size(), 1);
    if (wake_log.size() > 0) check("t2 wake id", wake_log[0], 3);

    // Fill, overflow, in-place update, removals.
    do_reset();
    tickval_in = 32'h100;
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, ID_W'(i), 32'd5);
    check("t3 full", full_out, 1);
    e0 = err_seen;
    do_op(1'b1, 1'b0, 8'd20, 32'd5);
    check("t3 overflow err", err_seen - e0, 1);
    check("t3 count stays", count_out, 16);
    e0 = err_seen;
    do_op(1'b1, 1'b0, 8'd4, 32'd9);
    check("t3 reinsert no err", err_seen - e0, 0);
    check("t3 model rewake", m_wake[4], 32'h109);
    do_op(1'b0, 1'b1, 8'd7, 32'd0);
    check("t4 count after remove", count_out, 15);
    e0 = err_seen;
    do_op(1'b0, 1'b1, 8'd7, 32'd0);
    check("t4 second remove err", err_seen - e0, 1);
    do_tick(32'h105, 1'b0, lat);
    check("t4 wakes at 0x105", wake_log.size(), 14);
    sevens = 0;
    foreach (wake_log[i]) if (wake_log[i] == 8'd7) sevens++;
    check("t4 no wake for 7", sevens, 0);
    do_tick(32'h109, 1'b0, lat);
    check("t4 late wake count", wake_log.size(), 15);
    if (wake_log.size() == 15) check("t4 late wake id", wake_log[14], 4);

    // Simultaneous expiry with a stalled consumer, plus a re-tick during the scan.
    do_reset();
    tickval_in = 32'h200;
    for (int i = 1; i <= 10; i++)
      do_op(1'b1, 1'b0, ID_W'(i), (i == 2 || i == 5 || i == 9) ? 32'd3 : 32'd100);
    // Back-to-back requests: the second finds the register occupied.
    @(posedge aclk);
    #1;
    e0 = err_seen;
    ins_dlylist_in = 1'b1;
    id_task_in = 8'd30;
    valuedelay_in = 32'd100;
    @(posedge aclk);
    #1;
    id_task_in = 8'd31;
    @(posedge aclk);
    #1;
    ins_dlylist_in = 1'b0;
    void'(m_apply(1'b1, 1'b0, 8'd30, tickval_in + 32'd100));
    repeat (3) @(posedge aclk);
    #1;
    check("t5 occupied drop err", err_seen - e0, 1);
    check("t5 count", count_out, 11);
    rdy_mode = 2;
    stall_n = 4;
    stall_cnt = 0;
    b0 = busy_rises;
    do_tick(32'h203, 1'b1, lat);
    check("t5 first wake latency", lat, 4);
    check("t5 scans", busy_rises - b0, 2);
    check("t5 wake count", wake_log.size(), 3);
    if (wake_log.size() == 3) begin
      check("t5 order 0", wake_log[0], 2);
      check("t5 order 1", wake_log[1], 5);
      check("t5 order 2", wake_log[2], 9);
    end

    // Reset while a wake is stalled.
    rdy_mode = 0;
    do_reset();
    tickval_in = 32'h300;
    do_op(1'b1, 1'b0, 8'd1, 32'd1);
    do_op(1'b1, 1'b0, 8'd2, 32'd1);
    rdy_mode = 2;
    stall_n = 1000;
    stall_cnt = 0;
    @(posedge aclk);
    #1;
    tickval_in = 32'h301;
    tick_in = 1'b1;
    @(posedge aclk);
    #1;
    tick_in = 1'b0;
    n = 0;
    while (!wake_valid_out && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("t7 emit reached", wake_valid_out, 1);
    #2;
    chk_en = 1'b0;
    aresetn = 1'b0;
    #1;
    check("t7 async valid drop", wake_valid_out, 0);
    check("t7 async count clear", count_out, 0);
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    wake_log.delete();
    rdy_mode = 0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    chk_en = 1'b1;
    do_tick(32'h310, 1'b0, lat);
    check("t7 no wakes after reset", wake_log.size(), 0);
    check("t7 empty", empty_out, 1);

    // Randomised traffic across a counter wrap.
    do_reset();
    rdy_mode = 1;
    tv = 32'hFFFF_FF80;
    tickval_in = tv;
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 19) == 0)
          do_op(1'b1, 1'b1, ID_W'($urandom_range(0, 23)), 32'd5);
        else if ($urandom_range(0, 9) < 7)
          do_op(1'b1, 1'b0, ID_W'($urandom_range(0, 23)), TICK_W'($urandom_range(0, 40)));
        else
          do_op(1'b0, 1'b1, ID_W'($urandom_range(0, 23)), 32'd0);
      end else begin
        tv = tv + TICK_W'($urandom_range(0, 15));
        do_tick(tv, 1'b0, lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
